// File: rtl/lfsr5_pkg.sv
// Shared definitions for the 5-bit LFSR pattern path: checker states,
// the generator's reset word, the lock-up word and the next-state function.
package lfsr5_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [4:0] LFSR5_SEED = 5'b11111;
  localparam logic [4:0] LFSR5_ZERO = 5'b00000;

  // nxt[0]=x[4], nxt[1]=x[0], nxt[2]=x[1], nxt[3]=x[4]^x[2], nxt[4]=x[4]^x[3]
  function automatic logic [4:0] lfsr5_next(input logic [4:0] x);
    lfsr5_next = {x[4] ^ x[3], x[4] ^ x[2], x[1], x[0], x[4]};
  endfunction

endpackage

// File: rtl/lfsr5_step.sv
// Combinational one-step advance of the 5-bit pattern LFSR.
module lfsr5_step
  import lfsr5_pkg::*;
(
  input  logic [4:0] x,
  output logic [4:0] y
);

  assign y = lfsr5_next(x);

endmodule

// File: rtl/lfsr5_checker.sv
// Pattern checker: self-synchronises a local LFSR copy to the incoming word
// stream, then flywheels and flags/counts every word that breaks the sequence.
module lfsr5_checker
  import lfsr5_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             in_valid,
  input  logic [4:0]       in_data,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic             lock_loss,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int CNT_MAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  // Compare against count-1 so the "+1 reaches the threshold" test stays in CNT_W bits.
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_CNT - 1);
  localparam logic [CNT_W-1:0] UNLOCK_LAST = CNT_W'(UNLOCK_CNT - 1);

  state_t           state_reg, state_next;
  logic [4:0]       exp_reg, exp_next;
  logic [CNT_W-1:0] match_reg, match_next;
  logic [CNT_W-1:0] miss_reg, miss_next;
  logic             locked_reg, locked_next;
  logic             err_pulse_reg, err_pulse_next;
  logic             lock_loss_reg, lock_loss_next;
  logic [ERR_W-1:0] err_cnt_reg, err_cnt_next;
  logic             count_err;
  logic [4:0]       nxt_in;
  logic [4:0]       nxt_exp;

  // Reseed path: successor of the sampled word.
  lfsr5_step u_step_in (
    .x (in_data),
    .y (nxt_in)
  );

  // Flywheel path: successor of the expected word.
  lfsr5_step u_step_exp (
    .x (exp_reg),
    .y (nxt_exp)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_reg <= HUNT;
    else        state_reg <= state_next;
  end

  // Datapath registers: expected word, run counters and registered outputs.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      exp_reg       <= LFSR5_SEED;
      match_reg     <= '0;
      miss_reg      <= '0;
      locked_reg    <= 1'b0;
      err_pulse_reg <= 1'b0;
      lock_loss_reg <= 1'b0;
      err_cnt_reg   <= '0;
    end else begin
      exp_reg       <= exp_next;
      match_reg     <= match_next;
      miss_reg      <= miss_next;
      locked_reg    <= locked_next;
      err_pulse_reg <= err_pulse_next;
      lock_loss_reg <= lock_loss_next;
      err_cnt_reg   <= err_cnt_next;
    end
  end

  // Next-state and output decode; only valid words advance the FSM.
  always_comb begin
    state_next     = state_reg;
    exp_next       = exp_reg;
    match_next     = match_reg;
    miss_next      = miss_reg;
    locked_next    = locked_reg;
    err_pulse_next = 1'b0;
    lock_loss_next = 1'b0;
    count_err      = 1'b0;

    if (in_valid) begin
      case (state_reg)
        HUNT: begin
          // The lock-up word cannot seed a useful sequence.
          if (in_data != LFSR5_ZERO) begin
            exp_next   = nxt_in;
            match_next = '0;
            state_next = SYNC;
          end
        end
        SYNC: begin
          if (in_data == exp_reg) begin
            exp_next   = nxt_in;
            match_next = match_reg + CNT_W'(1);
            if (match_reg == LOCK_LAST) begin
              state_next  = LOCKED;
              locked_next = 1'b1;
            end
          end else if (in_data != LFSR5_ZERO) begin
            exp_next   = nxt_in;
            match_next = '0;
          end else begin
            state_next = HUNT;
          end
        end
        LOCKED: begin
          // Flywheel: a corrupt word must never pull the local copy off sequence.
          exp_next = nxt_exp;
          if (in_data == exp_reg) begin
            miss_next = '0;
          end else begin
            err_pulse_next = 1'b1;
            count_err      = 1'b1;
            if (miss_reg == UNLOCK_LAST) begin
              state_next     = HUNT;
              locked_next    = 1'b0;
              lock_loss_next = 1'b1;
              miss_next      = '0;
            end else begin
              miss_next = miss_reg + CNT_W'(1);
            end
          end
        end
        default: begin
          state_next  = HUNT;
          locked_next = 1'b0;
        end
      endcase
    end

    // Clear wins over increment, but a mismatch on the clearing edge still counts once.
    if (clr_cnt) begin
      err_cnt_next = count_err ? ERR_W'(1) : '0;
    end else if (count_err && (err_cnt_reg != {ERR_W{1'b1}})) begin
      err_cnt_next = err_cnt_reg + ERR_W'(1);
    end else begin
      err_cnt_next = err_cnt_reg;
    end
  end

  assign locked    = locked_reg;
  assign err_pulse = err_pulse_reg;
  assign lock_loss = lock_loss_reg;
  assign err_cnt   = err_cnt_reg;

endmodule
